// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: IF/ID latch, decoder, bypassed 8x16 register file and ID/EX bundle
module instruction_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [2:0]  if_pc,
    input  logic [15:0] if_instruction,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        hazard_stall,
    output logic        id_valid,
    output logic [2:0]  id_pc,
    output logic [3:0]  id_opcode,
    output logic [2:0]  id_rd,
    output logic [2:0]  id_rs1,
    output logic [2:0]  id_rs2,
    output logic [15:0] id_rs1_data,
    output logic [15:0] id_rs2_data,
    output logic [15:0] id_imm,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_alu_src,
    output logic        id_branch,
    output logic        id_illegal,
    output logic        halted
);
    logic [2:0]  ifid_pc;
    logic [15:0] ifid_instr;
    logic        ifid_valid;
    logic [15:0] regs [8];
    logic [3:0]  op;
    logic [2:0]  rs1, rs2;
    logic        use1, use2, ld, upd, dv;
    logic [15:0] d1, d2;
    always_comb begin
        op = ifid_instr[15:12];
        rs1 = ifid_instr[8:6];
        rs2 = (op == 4'h7 || op == 4'h8) ? ifid_instr[11:9] : ifid_instr[5:3];
        use1 = op >= 4'h1 && op <= 4'h8;
        use2 = use1 && op != 4'h5 && op != 4'h6;
        d1 = rs1 == 3'd0 ? 16'd0 : (wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
        d2 = rs2 == 3'd0 ? 16'd0 : (wb_en && wb_addr == rs2) ? wb_data : regs[rs2];
        hazard_stall = id_valid && id_mem_read && id_rd != 3'd0 && ifid_valid &&
                       ((use1 && rs1 == id_rd) || (use2 && rs2 == id_rd));
        ld = !flush && !stall && !hazard_stall && !halted;
        upd = flush || !stall;
        dv = ld && ifid_valid;
    end
    // ld=0 with upd=1 inserts a bubble; ld=1 with an invalid IF/ID passes fields but no control
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_pc <= '0;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
            id_valid <= 1'b0;
            id_pc <= '0;
            id_opcode <= '0;
            id_rd <= '0;
            id_rs1 <= '0;
            id_rs2 <= '0;
            id_rs1_data <= '0;
            id_rs2_data <= '0;
            id_imm <= '0;
            id_reg_write <= 1'b0;
            id_mem_read <= 1'b0;
            id_mem_write <= 1'b0;
            id_alu_src <= 1'b0;
            id_branch <= 1'b0;
            id_illegal <= 1'b0;
            halted <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (wb_en && wb_addr != 3'd0) regs[wb_addr] <= wb_data;
            if (flush) ifid_valid <= 1'b0;
            else if (!stall && !hazard_stall) begin
                ifid_pc <= if_pc;
                ifid_instr <= if_instruction;
                ifid_valid <= !halted;
            end
            if (upd) begin
                id_valid <= dv;
                id_pc <= ld ? ifid_pc : '0;
                id_opcode <= ld ? op : '0;
                id_rd <= ld ? ifid_instr[11:9] : '0;
                id_rs1 <= ld ? rs1 : '0;
                id_rs2 <= ld ? rs2 : '0;
                id_rs1_data <= ld ? d1 : '0;
                id_rs2_data <= ld ? d2 : '0;
                id_imm <= ld ? {{10{ifid_instr[5]}}, ifid_instr[5:0]} : '0;
                id_reg_write <= dv && op >= 4'h1 && op <= 4'h6;
                id_mem_read <= dv && op == 4'h6;
                id_mem_write <= dv && op == 4'h7;
                id_alu_src <= dv && op >= 4'h5 && op <= 4'h7;
                id_branch <= dv && op == 4'h8;
                id_illegal <= dv && op > 4'h8 && op != 4'hF;
                halted <= halted || (dv && op == 4'hF);
            end
        end
    end
endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Second pipeline stage of the 16-bit RISC CPU. It registers the PC/instruction pair produced by the fetch stage into an IF/ID latch and decodes the opcode and fields. It reads an 8x16 register file that has a write-back port and detects load-use hazards. Its output is a registered ID/EX bundle for the execute stage, and it supports stall, flush and sticky HALT.

## Interface
- No parameters; widths are fixed: PC 3 bits, instruction 16 bits, 8 registers of 16 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: downstream hold; freeze IF/ID and ID/EX.
- `flush` in 1: squash IF/ID contents (taken branch).
- `if_pc` in 3: PC from fetch.
- `if_instruction` in 16: instruction from fetch.
- `wb_en` in 1: register write enable.
- `wb_addr` in 3: write register.
- `wb_data` in 16: write data.
- `hazard_stall` out 1: combinational; tells fetch to hold PC.
- `id_valid` out 1: ID/EX holds a real instruction.
- `id_pc` out 3: PC of the instruction in ID/EX.
- `id_opcode` out 4: opcode of the instruction in ID/EX.
- `id_rd` out 3: destination register.
- `id_rs1` out 3: source register 1.
- `id_rs2` out 3: source register 2.
- `id_rs1_data` out 16: operand read for rs1.
- `id_rs2_data` out 16: operand read for rs2.
- `id_imm` out 16: sign-extended imm6.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_alu_src`, `id_branch` out 1 each: control bits.
- `id_illegal` out 1: unrecognised opcode.
- `halted` out 1: sticky; set once HALT reaches ID/EX.

## Operation
- **Encoding:** op=[15:12]. R-type uses rd=[11:9], rs1=[8:6], rs2=[5:3]. I-type uses rd=[11:9], rs1=[8:6], imm6=[5:0].
- **Opcodes:**
  - 0000 NOP: all control bits 0.
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR: reg_write=1; reads rs1 and rs2.
  - 0101 ADDI: reg_write=1, alu_src=1; reads rs1.
  - 0110 LW: reg_write=1, mem_read=1, alu_src=1; reads rs1.
  - 0111 SW: mem_write=1, alu_src=1; rs2 field := [11:9]; reads rs1 and rs2.
  - 1000 BEQ: branch=1; rs2 field := [11:9]; reads rs1 and rs2.
  - 1111 HALT: all control bits 0.
  - Any other opcode: decoded as NOP with id_illegal=1.
- **Immediate:** id_imm = {{10{instr[5]}}, instr[5:0]} for every opcode.
- **Register file:**
  - 8x16; r0 reads 0 and ignores writes.
  - Write on the clock edge when wb_en=1 and wb_addr≠0.
  - Read bypass: if wb_en=1, wb_addr≠0 and wb_addr matches the read address, the read returns wb_data in the same cycle.
- **Load-use hazard:** hazard_stall = id_valid & id_mem_read & id_rd≠0 & ifid_valid & (id_rd matches a source register actually read by the IF/ID instruction).
- **Per-edge priority (highest first):**
  1. reset: clear everything.
  2. flush: ifid_valid←0; ID/EX←bubble (id_valid=0, all control bits 0).
  3. stall: IF/ID and ID/EX hold.
  4. hazard_stall: IF/ID holds; ID/EX←bubble.
  5. Normal: IF/ID←{if_pc, if_instruction, valid=1}; ID/EX←decoded IF/ID contents with id_valid=ifid_valid.
- **HALT:**
  - When a valid HALT enters ID/EX, halted←1.
  - While halted: IF/ID loads force ifid_valid=0, and ID/EX receives only bubbles.
  - Only reset clears halted.
- A bubble or invalid entry never drives reg_write, mem_write, mem_read, branch or illegal high.

## Timing
- **Reset values:**
  - All outputs 0, including hazard_stall and halted.
  - All eight registers 0; ifid_valid=0.
- **Latency:** fetch values present before edge N are in IF/ID after edge N and appear on the id_* outputs after edge N+1, i.e. 2 edges.
- **First instruction:** the first edge with reset=0 loads IF/ID; id_valid first rises one edge later.
- **hazard_stall** is combinational from IF/ID and ID/EX state; it is held for exactly one cycle per load-use pair.
- **Same-cycle write-back:** a write-back in the same cycle as decode is visible in id_rs*_data on the next edge via the bypass.
- **Flush with stall:** flush wins.
- **Stall with hazard:** everything holds; the hazard re-evaluates next cycle.
- **Reset mid-stream:** discards all in-flight state in one edge.

## Test plan
- Reset for 1 cycle, then apply NOP stream → all outputs 0 during reset; id_valid=1 two edges after reset falls.
- Preload r1=5 and r2=7 via wb, then feed ADD r3,r1,r2 (0x1650) → after 2 edges: id_opcode=1, id_rs1_data=5, id_rs2_data=7, id_reg_write=1.
- ADDI r1,r0,-1 (0x523F) → id_imm=0xFFFF, id_alu_src=1.
- Same-cycle bypass: wb_en=1, wb_addr=1, wb_data=0xAAAA while decoding ADD r3,r1,r2 → id_rs1_data=0xAAAA; write to r0 → r0 still reads 0.
- LW r2,0(r1) (0x6440) followed by ADD r3,r2,r2 (0x1690) → hazard_stall=1 for one cycle, one bubble (id_valid=0), then ADD with id_rs1=id_rs2=2.
- Flush asserted together with stall → next ID/EX is a bubble. HALT (0xF000) → halted=1 and id_valid=0 afterwards until reset; opcode 0xA → id_illegal=1, id_reg_write=0.
